// File: rtl/dac_tx.sv
// dac_tx: two-channel serial transmitter for a pair of DAC121S101-class DACs
// that share SCLK and SYNC. One sample is taken per valid/ready handshake. Two
// 16-bit frames {2'b00, pd_mode, code} are shifted out MSB first, in lockstep.
// Optional build macro DAC_HOLD_EN: keeps the last accepted frames and re-sends
// them from IDLE whenever no new sample is offered (auto-refresh).
module dac_tx #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [DATA_WIDTH-1:0] d_ch0,
    input  logic [DATA_WIDTH-1:0] d_ch1,
    input  logic [1:0]            pd_mode,
    output logic                  dac_clk,
    output logic                  dac_sync,
    output logic                  dac_d0,
    output logic                  dac_d1,
    output logic                  busy
);

    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;     // cycles spent in current half-period
    logic [3:0]    bcnt_q, bcnt_d;     // bit index within the frame, 0..15
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          phase_q, phase_d;   // 0: SCLK low half, 1: SCLK high half
    logic [15:0]   sh0_q, sh0_d;       // bit 15 drives the data line directly
    logic [15:0]   sh1_q, sh1_d;
    logic          sclk_q, sclk_d;
    logic          sync_q, sync_d;
    logic          rdy_q, rdy_d;
    logic          busy_q, busy_d;

    logic [15:0]   frm0, frm1;
    logic [15:0]   src0, src1;
    logic          start;

`ifdef DAC_HOLD_EN
    logic [15:0]   held0_q, held0_d;
    logic [15:0]   held1_q, held1_d;
    logic          have_q, have_d;
`endif

    assign frm0 = {2'b00, pd_mode, d_ch0};
    assign frm1 = {2'b00, pd_mode, d_ch1};

    assign dac_clk  = sclk_q;
    assign dac_sync = sync_q;
    assign dac_d0   = sh0_q[15];
    assign dac_d1   = sh1_q[15];
    assign d_ready  = rdy_q;
    assign busy     = busy_q;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        phase_d = phase_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        sclk_d  = sclk_q;
        sync_d  = sync_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        start   = 1'b0;
        src0    = frm0;
        src1    = frm1;
`ifdef DAC_HOLD_EN
        held0_d = held0_q;
        held1_d = held1_q;
        have_d  = have_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (d_valid) begin
                    start = 1'b1;
`ifdef DAC_HOLD_EN
                    // A fresh sample always beats the refresh of the held one.
                    held0_d = frm0;
                    held1_d = frm1;
                    have_d  = 1'b1;
                end else if (have_q) begin
                    start = 1'b1;
                    src0  = held0_q;
                    src1  = held1_q;
`endif
                end
                if (start) begin
                    state_d = S_LOAD;
                    hcnt_d  = '0;
                    sh0_d   = src0;
                    sh1_d   = src1;
                    sync_d  = 1'b0;
                    sclk_d  = 1'b1;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                // SYNC-to-SCLK setup, then the first falling edge.
                if (hcnt_q == H_LAST) begin
                    state_d = S_SHIFT;
                    hcnt_d  = '0;
                    bcnt_d  = '0;
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (hcnt_q != H_LAST) begin
                    hcnt_d = hcnt_q + 1'b1;
                end else begin
                    hcnt_d = '0;
                    if (!phase_q) begin
                        // Rising edge: data advances, keeping it stable a full
                        // half-period on either side of each falling edge.
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                        sh0_d   = {sh0_q[14:0], 1'b0};
                        sh1_d   = {sh1_q[14:0], 1'b0};
                    end else if (bcnt_q == 4'd15) begin
                        // Sixteen shifts have emptied the registers, so the
                        // data lines are already 0 for the gap.
                        state_d = S_GAP;
                        gcnt_d  = '0;
                        sync_d  = 1'b1;
                    end else begin
                        bcnt_d  = bcnt_q + 1'b1;
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q == G_LAST) begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
                sync_d  = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            phase_q <= 1'b0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sclk_q  <= 1'b1;
            sync_q  <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            phase_q <= phase_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sclk_q  <= sclk_d;
            sync_q  <= sync_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

`ifdef DAC_HOLD_EN
    // Held-sample storage for auto-refresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held0_q <= '0;
            held1_q <= '0;
            have_q  <= 1'b0;
        end else begin
            held0_q <= held0_d;
            held1_q <= held1_d;
            have_q  <= have_d;
        end
    end
`endif

endmodule

// File: tb/tb_dac_tx.sv
// Directed bench for dac_tx at CLK_DIV=2, GAP_CYCLES=4. A frame takes 66
// cycles with SYNC low, 4 gap cycles, and d_ready returns 70 cycles after
// acceptance. Outputs are sampled on the falling system-clock edge.
module tb_dac_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_valid = 1'b0;
    logic [11:0] d_ch0 = '0;
    logic [11:0] d_ch1 = '0;
    logic [1:0]  pd_mode = '0;
    logic        d_ready, dac_clk, dac_sync, dac_d0, dac_d1, busy;

    dac_tx #(.CLK_DIV(2), .GAP_CYCLES(4), .DATA_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_ready(d_ready),
        .d_ch0(d_ch0), .d_ch1(d_ch1), .pd_mode(pd_mode),
        .dac_clk(dac_clk), .dac_sync(dac_sync), .dac_d0(dac_d0),
        .dac_d1(dac_d1), .busy(busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    // Observation results, filled by observe().
    logic [15:0] fr0 [4];
    logic [15:0] fr1 [4];
    int          sf [4];
    int          nfall, nsf, sync_low_n, first_ready, busy_drop, gap_n;
    int          idle_clk_err, acc2;

    // Called at the first falling clk edge after an acceptance edge. Sample k
    // therefore sees the outputs produced by the edge k-1 cycles after it.
    task automatic observe(input int ncyc, input int acc_limit, input int pulse_at);
        bit pclk;
        bit psync;
        bit drop;
        int nacc;
        pclk = 1'b1; psync = 1'b1; drop = 1'b0; nacc = 1;
        nfall = 0; nsf = 0; sync_low_n = 0; first_ready = -1; busy_drop = -1;
        gap_n = 0; idle_clk_err = 0; acc2 = -1;
        for (int i = 0; i < 4; i++) begin
            fr0[i] = '0; fr1[i] = '0; sf[i] = -1;
        end
        for (int k = 1; k <= ncyc; k++) begin
            if (k > 1) @(negedge clk);
            if (drop) begin d_valid = 1'b0; drop = 1'b0; end
            if (k == pulse_at) begin
                d_valid = 1'b1; d_ch0 = 12'h555; d_ch1 = 12'h555; drop = 1'b1;
            end
            if (!dac_sync) sync_low_n++;
            if (psync && !dac_sync) begin
                if (nsf < 4) sf[nsf] = k - 1;
                nsf++;
            end
            if (pclk && !dac_clk) begin
                if (nfall < 64) begin
                    fr0[nfall/16] = {fr0[nfall/16][14:0], dac_d0};
                    fr1[nfall/16] = {fr1[nfall/16][14:0], dac_d1};
                end
                nfall++;
            end
            if (dac_sync && !dac_clk) idle_clk_err++;
            if (dac_sync && busy && nsf == 1) gap_n++;
            if (d_ready && first_ready < 0) first_ready = k - 1;
            if (!busy && busy_drop < 0) busy_drop = k - 1;
            if (d_valid && d_ready) begin
                nacc++;
                if (acc2 < 0) acc2 = k;
                if (nacc >= acc_limit) drop = 1'b1;
            end
            pclk = dac_clk; psync = dac_sync;
        end
    endtask

    // Wait for d_ready, present a sample, and return just after acceptance.
    task automatic send(input logic [11:0] a, input logic [11:0] b,
                        input logic [1:0] m, input bit keep_valid);
        int w;
        w = 0;
        @(negedge clk);
        while (!d_ready && w < 300) begin @(negedge clk); w++; end
        nchk++;
        if (d_ready !== 1'b1) begin
            nfail++;
            $display("FAIL send_wait: d_ready=%b required 1", d_ready);
        end
        d_ch0 = a; d_ch1 = b; pd_mode = m; d_valid = 1'b1;
        @(negedge clk);
        if (!keep_valid) d_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nchk++; if (dac_sync !== 1'b1) begin nfail++; $display("FAIL reset_sync: got %b want 1", dac_sync); end
        nchk++; if (dac_clk !== 1'b1) begin nfail++; $display("FAIL reset_sclk: got %b want 1", dac_clk); end
        nchk++; if ({dac_d0, dac_d1} !== 2'b00) begin nfail++; $display("FAIL reset_data: got %b%b want 00", dac_d0, dac_d1); end
        nchk++; if (d_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b want 1", d_ready); end
        nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        send(12'hABC, 12'h123, 2'b00, 1'b0);
        observe(71, 1, 0);
        nchk++; if (fr0[0] !== 16'h0ABC) begin nfail++; $display("FAIL single_d0: got %h want 0abc", fr0[0]); end
        nchk++; if (fr1[0] !== 16'h0123) begin nfail++; $display("FAIL single_d1: got %h want 0123", fr1[0]); end
        nchk++; if (nfall !== 16) begin nfail++; $display("FAIL single_falls: got %0d want 16", nfall); end
        nchk++; if (sf[0] !== 0) begin nfail++; $display("FAIL single_sync_start: got %0d want 0", sf[0]); end
        nchk++; if (sync_low_n !== 66) begin nfail++; $display("FAIL single_sync_low: got %0d want 66", sync_low_n); end
        nchk++; if (first_ready !== 70) begin nfail++; $display("FAIL single_ready: got %0d want 70", first_ready); end
        nchk++; if (busy_drop !== 70) begin nfail++; $display("FAIL single_busy: got %0d want 70", busy_drop); end
        nchk++; if (gap_n !== 4) begin nfail++; $display("FAIL single_gap: got %0d want 4", gap_n); end
        nchk++; if (idle_clk_err !== 0) begin nfail++; $display("FAIL single_sclk_idle: got %0d want 0", idle_clk_err); end
`ifndef DAC_HOLD_EN
        observe(150, 1, 0);
        nchk++; if (nsf !== 0) begin nfail++; $display("FAIL single_only_one: got %0d extra frames want 0", nsf); end
        nchk++; if (nfall !== 0) begin nfail++; $display("FAIL single_idle_sclk: got %0d falls want 0", nfall); end
`endif
    endtask

    task automatic test_mode_bits();
        send(12'hFFF, 12'h000, 2'b11, 1'b0);
        observe(71, 1, 0);
        nchk++; if (fr0[0] !== 16'h3FFF) begin nfail++; $display("FAIL mode_d0: got %h want 3fff", fr0[0]); end
        nchk++; if (fr1[0] !== 16'h3000) begin nfail++; $display("FAIL mode_d1: got %h want 3000", fr1[0]); end
    endtask

    task automatic test_back_to_back();
        send(12'h111, 12'h222, 2'b00, 1'b1);
        d_ch0 = 12'h333; d_ch1 = 12'h444;
        observe(150, 2, 0);
        nchk++; if (acc2 !== 71) begin nfail++; $display("FAIL b2b_spacing: got %0d want 71", acc2); end
        nchk++; if (gap_n !== 4) begin nfail++; $display("FAIL b2b_gap: got %0d want 4", gap_n); end
        nchk++; if (sf[1] !== 71) begin nfail++; $display("FAIL b2b_sync2: got %0d want 71", sf[1]); end
        nchk++; if (fr0[0] !== 16'h0111 || fr1[0] !== 16'h0222) begin nfail++; $display("FAIL b2b_frame1: got %h/%h want 0111/0222", fr0[0], fr1[0]); end
        nchk++; if (fr0[1] !== 16'h0333 || fr1[1] !== 16'h0444) begin nfail++; $display("FAIL b2b_frame2: got %h/%h want 0333/0444", fr0[1], fr1[1]); end
    endtask

    task automatic test_busy_ignore();
        send(12'h0AA, 12'h055, 2'b00, 1'b0);
        observe(71, 1, 20);
        nchk++; if (fr0[0] !== 16'h00AA || fr1[0] !== 16'h0055) begin nfail++; $display("FAIL busy_frame: got %h/%h want 00aa/0055", fr0[0], fr1[0]); end
        nchk++; if (busy_drop !== 70) begin nfail++; $display("FAIL busy_held: got %0d want 70", busy_drop); end
        nchk++; if (first_ready !== 70) begin nfail++; $display("FAIL busy_ready: got %0d want 70", first_ready); end
        nchk++; if (nsf !== 1) begin nfail++; $display("FAIL busy_frames: got %0d want 1", nsf); end
    endtask

    task automatic test_reset_abort();
        int  f;
        int  w;
        bit  pc;
        send(12'hFFF, 12'hFFF, 2'b00, 1'b0);
        f = 0; w = 0; pc = dac_clk;
        while (f < 8 && w < 200) begin
            @(negedge clk);
            if (pc && !dac_clk) f++;
            pc = dac_clk; w++;
        end
        nchk++; if (f !== 8) begin nfail++; $display("FAIL abort_reach: got %0d falls want 8", f); end
        rst = 1'b1;
        #1;
        nchk++; if (dac_sync !== 1'b1) begin nfail++; $display("FAIL abort_sync: got %b want 1", dac_sync); end
        nchk++; if (dac_clk !== 1'b1) begin nfail++; $display("FAIL abort_sclk: got %b want 1", dac_clk); end
        nchk++; if ({dac_d0, dac_d1} !== 2'b00) begin nfail++; $display("FAIL abort_data: got %b%b want 00", dac_d0, dac_d1); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        observe(100, 1, 0);
        nchk++; if (first_ready !== 0) begin nfail++; $display("FAIL abort_ready: got %0d want 0", first_ready); end
        nchk++; if (busy_drop !== 0) begin nfail++; $display("FAIL abort_busy: got %0d want 0", busy_drop); end
        nchk++; if (nsf !== 0 || nfall !== 0) begin nfail++; $display("FAIL abort_quiet: got %0d syncs %0d falls want 0/0", nsf, nfall); end
        nchk++; if (idle_clk_err !== 0) begin nfail++; $display("FAIL abort_sclk_idle: got %0d want 0", idle_clk_err); end
    endtask

`ifdef DAC_HOLD_EN
    task automatic test_hold();
        send(12'h800, 12'h800, 2'b00, 1'b0);
        observe(150, 1, 0);
        nchk++; if (sf[1] !== 71) begin nfail++; $display("FAIL hold_refresh: got %0d want 71", sf[1]); end
        nchk++; if (fr0[0] !== 16'h0800 || fr1[0] !== 16'h0800) begin nfail++; $display("FAIL hold_frame1: got %h/%h want 0800/0800", fr0[0], fr1[0]); end
        nchk++; if (fr0[1] !== 16'h0800 || fr1[1] !== 16'h0800) begin nfail++; $display("FAIL hold_frame2: got %h/%h want 0800/0800", fr0[1], fr1[1]); end
        send(12'h100, 12'h200, 2'b00, 1'b0);
        observe(71, 1, 0);
        nchk++; if (fr0[0] !== 16'h0100 || fr1[0] !== 16'h0200) begin nfail++; $display("FAIL hold_new: got %h/%h want 0100/0200", fr0[0], fr1[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_mode_bits();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
`ifdef DAC_HOLD_EN
        test_hold();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/dac_tx.md
Name: dac_tx

Overview:
- Serial transmitter for the dual-channel 12-bit DAC Pmod (two DAC121S101-class devices sharing SCLK and SYNC, one data line each).
- It is the write-side counterpart of the ADC capture path and sits on the same Pmod-style header.
- Accepts one two-channel sample per valid/ready handshake and shifts out two simultaneous 16-bit frames, MSB first.
- Used to drive analogue output, such as a test tone or an RPM-proportional voltage.

Parameters:
- CLK_DIV, 2: system clocks per SCLK half-period. Must be ≥1.
- GAP_CYCLES, 4: system clocks SYNC stays high after a frame, before the next can start. Must be ≥1.
- DATA_WIDTH, 12: DAC code width. Frame is fixed at 16 bits = {2'b00, pd_mode[1:0], data[11:0]}.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- d_valid, in, 1: sample available.
- d_ready, out, 1: block can accept a sample.
- d_ch0, in, 12: channel 0 code, sampled only at acceptance.
- d_ch1, in, 12: channel 1 code, sampled only at acceptance.
- pd_mode, in, 2: DAC power-down mode bits, sampled at acceptance; 00 = normal operation.
- dac_clk, out, 1: SCLK; idles high.
- dac_sync, out, 1: SYNC, active low; idles high.
- dac_d0, out, 1: serial data, channel 0.
- dac_d1, out, 1: serial data, channel 1.
- busy, out, 1: high whenever state ≠ IDLE.

Behaviour:
- Reset values: dac_sync=1, dac_clk=1, dac_d0=0, dac_d1=0, d_ready=1, busy=0, state=IDLE, shift registers=0, counters=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Acceptance: at a clk edge where d_valid && d_ready. The block latches both 16-bit frames and enters LOAD.
- d_valid while d_ready=0 is ignored. Data inputs are don't-care outside the acceptance edge.
- IDLE: d_ready=1, SYNC high, SCLK high, data lines 0.
- LOAD:
  - SYNC=0, SCLK=1, data lines = bit 15 of each frame.
  - Duration CLK_DIV cycles (SYNC-to-SCLK setup).
- SHIFT, for each bit 15..0:
  - SCLK falls (the DAC samples on this edge) and stays low for CLK_DIV cycles.
  - SCLK rises and stays high for CLK_DIV cycles; data lines advance to the next bit on this rising edge.
  - Data is therefore stable a full half-period around each falling edge.
  - Bit counter counts 0..15. After the 16th high half-period, go to GAP.
- SYNC low duration = 33·CLK_DIV cycles, with exactly 16 SCLK falling edges while SYNC is low.
- GAP:
  - SYNC=1, SCLK=1, data lines 0, d_ready=0.
  - Duration GAP_CYCLES, then IDLE.
- Throughput: d_ready returns high 33·CLK_DIV+GAP_CYCLES cycles after the acceptance edge. Minimum acceptance spacing is 33·CLK_DIV+GAP_CYCLES+1 (71 at defaults).
- Both channels shift in lockstep; there is no per-channel skew.
- Reset mid-frame:
  - Outputs go to reset values immediately (asynchronous).
  - SYNC rising before the 16th falling edge aborts the DAC write, so no partial code is loaded.
- Half-period counter width is clog2(CLK_DIV)+1, and the counter wraps only via explicit reload. There is no free-running wrap.

Optional Feature:
- Macro: DAC_HOLD_EN.
- When defined:
  - The block keeps the last accepted frames plus a have_sample flag (reset 0).
  - In IDLE with have_sample=1 and d_valid=0, it immediately starts a new LOAD with the held frames (auto-refresh).
  - d_ready is still 1 in that IDLE cycle. If d_valid=1 in the same cycle, the new sample wins and replaces the held frames.
- When undefined: the block idles indefinitely in IDLE after a frame and has no held-sample storage.

Test Plan:
- Single frame:
  - Stimulus: CLK_DIV=2, GAP=4; accept d_ch0=0xABC, d_ch1=0x123, pd_mode=00.
  - Required: bits captured on the 16 SCLK falling edges are 0x0ABC on d0 and 0x0123 on d1; SYNC low for exactly 66 cycles; d_ready high again 70 cycles after the acceptance edge.
- Mode bits:
  - Stimulus: pd_mode=11, d_ch0=0xFFF, d_ch1=0x000.
  - Required: d0 frame = 0x3FFF, d1 frame = 0x3000.
- Back-to-back:
  - Stimulus: d_valid held high; first sample 0x111/0x222, second sample 0x333/0x444.
  - Required: second acceptance exactly 71 cycles after the first; SYNC high for 4 cycles between frames; second frame carries 0x0333/0x0444.
- Busy-time ignore:
  - Stimulus: pulse d_valid with 0x555 during a SHIFT.
  - Required: no acceptance; the current frame is unchanged; busy stays 1.
- Reset abort:
  - Stimulus: assert rst after the 8th falling edge.
  - Required: SYNC=1, SCLK=1, data lines 0 within the same cycle; d_ready=1 and busy=0 after release; no further SCLK edges.
- DAC_HOLD_EN:
  - Stimulus: accept 0x800/0x800 once, then keep d_valid=0.
  - Required: frames repeat every 71 cycles carrying 0x0800.
  - Stimulus: then offer 0x100/0x200.
  - Required: the next frame carries 0x0100/0x0200.
  - Required with the macro undefined: exactly one frame.
